dmem_sram_responder: RTL and testbench
======================================

Name: dmem_sram_responder

Overview:
- Slave end of the core's data-side SRAM-like interface: accepts mem_en/mem_wen/mem_addr/mem_wdata/data_size requests from the memory stage and returns mem_rdata with configurable latency.
- Holds the pipeline with mem_stall while a request is in flight.
- Contains a word-organised, byte-writable storage array. Used as the on-chip data RAM and as the bench model for the memory stage.

Parameters:
- ADDR_WIDTH, 12, word-address bits; storage depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra busy cycles before the array access (0..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset; rst==0 at a rising edge resets.
- mem_en  input  1  request valid.
- mem_wen  input  4  byte-lane write enables; 0 means read.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data, already lane-replicated by the master.
- data_size  input  3  0=byte, 1=half, 2=word; informational, captured for debug only.
- mem_rdata  output  32  full read word, valid when resp_valid.
- mem_stall  output  1  master must hold the request and freeze.
- resp_valid  output  1  one-cycle response pulse.
- bus_error  output  1  one-cycle pulse, request was out of range.

Behaviour:
- States: IDLE, BUSY, RESP. 4-bit wait counter cnt. Request registers: req_addr, req_wen, req_wdata, req_size.
- Reset (rst==0): state=IDLE, cnt=0, mem_rdata=0, resp_valid=0, bus_error=0, request registers=0. The storage array is not reset.
- A reset during BUSY aborts the request; no array write occurs.
- mem_stall is combinational: (state==IDLE && mem_en) || state==BUSY. It is never asserted in RESP.
- IDLE, mem_en=1:
  - Latch the request.
  - Set cnt=WAIT_CYCLES.
  - Go to BUSY.
- IDLE, mem_en=0: remain in IDLE.
- BUSY, cnt!=0: decrement cnt.
- BUSY, cnt==0: perform the access and go to RESP.
  - In range (req_addr[31:ADDR_WIDTH+2]==0), word index req_addr[ADDR_WIDTH+1:2]:
    - Write each lane i with req_wen[i]=1 from req_wdata[8i+7:8i].
    - Register mem_rdata = the array word read before the write, so a write returns the old word.
  - Out of range: no write, mem_rdata=0, register bus_error=1.
- RESP:
  - resp_valid=1 and mem_stall=0.
  - Go to IDLE. resp_valid and bus_error return to 0 on the next edge.
  - mem_en in the RESP cycle is ignored; the master presents the next request in the following cycle.
- Latency: request accepted at cycle T gives resp_valid at T+WAIT_CYCLES+2. mem_stall is high from T through T+WAIT_CYCLES+1.
- mem_rdata holds its value until the next access cycle.
- Address bits [1:0] are ignored. The array never shifts lanes: the master performs lane selection and sign extension on reads, and lane replication on writes.
- req_size has no functional effect.

Optional Feature:
- Macro: DMEM_POSTED_WRITE_EN.
- Defined:
  - In IDLE, mem_en=1 with |mem_wen=1 is posted. mem_stall=0 in the accept cycle and there is no RESP or resp_valid.
  - The write is latched into a one-entry write buffer and committed to the array on the next rising edge.
  - Back-to-back posted writes are allowed, one per cycle.
  - Out-of-range posted write: discarded, bus_error pulses one cycle after acceptance.
  - Reads always take the BUSY path, so a read after a write always sees committed data.
  - Reset clears the buffer valid bit; an uncommitted write is lost.
- Undefined: writes follow the full IDLE/BUSY/RESP path, identical to reads.

Test Plan:
- Reset with WAIT_CYCLES=2: hold rst=0 for 3 cycles -> mem_stall=0, resp_valid=0, bus_error=0, mem_rdata=0.
- Word write then read at WAIT_CYCLES=2, accept at T:
  - Write mem_addr=0x10, wen=4'b1111, wdata=0xDEADBEEF.
  - Then read 0x10 -> write stalls T..T+3 with resp_valid at T+4.
  - The read returns mem_rdata=0xDEADBEEF.
- Byte merge: with word 0x10=0xDEADBEEF, write wen=4'b0100, wdata=0x55555555, then read 0x13 -> mem_rdata=0xDE55BEEF.
- Out of range with ADDR_WIDTH=12: write to 0x00004000 -> bus_error=1 and resp_valid=1 in the same cycle; the array is unchanged and a read of 0x0 returns its prior value.
- WAIT_CYCLES=0 back-to-back: three reads presented whenever mem_stall falls -> each resp_valid exactly 2 cycles after its accept, with no lost or duplicated response.
- DMEM_POSTED_WRITE_EN:
  - Stimulus: writes to 0x20 and 0x24 on consecutive cycles (0x11111111, 0x22222222), then a read of 0x24.
  - Both writes are accepted with mem_stall=0.
  - The read returns 0x22222222.
  - Separately, reset asserted in the cycle after a posted write to 0x28 -> 0x28 keeps its old value.

Source files
------------

// File: rtl/dmem_sram_responder.sv
// Data-side SRAM-like slave: byte-writable word array behind a fixed wait-state handshake.
// Optional: define DMEM_POSTED_WRITE_EN to post writes through a one-entry write buffer.
module dmem_sram_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  data_size,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        resp_valid,
  output logic        bus_error
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                r_state, w_state_d;
  logic [3:0]            r_cnt, w_cnt_d;
  logic [31:0]           r_req_addr, r_req_wdata, r_rdata;
  logic [3:0]            r_req_wen;
  logic [2:0]            r_req_size;
  logic                  r_bus_error, w_bus_error_d;
  logic                  w_latch, w_access, w_in_range, w_post, w_post_err;
  logic [ADDR_WIDTH-1:0] w_req_idx, w_wr_idx;
  logic [3:0]            w_wr_lanes;
  logic [31:0]           w_wr_data;
  logic                  w_unused_ok;
  logic [31:0]           r_mem [2**ADDR_WIDTH];

  assign w_in_range  = (r_req_addr[31:ADDR_WIDTH+2] == '0);
  assign w_req_idx   = r_req_addr[ADDR_WIDTH+1:2];
  // Size and byte offset are kept for debug visibility only.
  assign w_unused_ok = ^{r_req_size, r_req_addr[1:0]};

`ifdef DMEM_POSTED_WRITE_EN
  logic                  r_wb_valid;
  logic [ADDR_WIDTH-1:0] r_wb_idx;
  logic [3:0]            r_wb_wen;
  logic [31:0]           r_wb_wdata;
  logic                  w_post_in_range;

  assign w_post          = (r_state == StIdle) && mem_en && (mem_wen != 4'b0000);
  assign w_post_in_range = (mem_addr[31:ADDR_WIDTH+2] == '0);
  assign w_post_err      = w_post && !w_post_in_range;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_idx   <= '0;
      r_wb_wen   <= '0;
      r_wb_wdata <= '0;
    end else begin
      r_wb_valid <= w_post && w_post_in_range;
      if (w_post) begin
        r_wb_idx   <= mem_addr[ADDR_WIDTH+1:2];
        r_wb_wen   <= mem_wen;
        r_wb_wdata <= mem_wdata;
      end
    end
  end

  // The BUSY path only carries reads here, so the two write sources never collide.
  assign w_wr_lanes = r_wb_valid ? r_wb_wen : ((w_access && w_in_range) ? r_req_wen : 4'b0000);
  assign w_wr_idx   = r_wb_valid ? r_wb_idx : w_req_idx;
  assign w_wr_data  = r_wb_valid ? r_wb_wdata : r_req_wdata;
`else
  assign w_post     = 1'b0;
  assign w_post_err = 1'b0;
  assign w_wr_lanes = (w_access && w_in_range) ? r_req_wen : 4'b0000;
  assign w_wr_idx   = w_req_idx;
  assign w_wr_data  = r_req_wdata;
`endif

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_latch   = 1'b0;
    w_access  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (mem_en && !w_post) begin
          w_latch   = 1'b1;
          w_cnt_d   = 4'(WAIT_CYCLES);
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        if (r_cnt != 4'd0) begin
          w_cnt_d = r_cnt - 4'd1;
        end else begin
          w_access  = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    w_bus_error_d = (w_access && !w_in_range) || w_post_err;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_req_addr  <= '0;
      r_req_wen   <= '0;
      r_req_wdata <= '0;
      r_req_size  <= '0;
      r_rdata     <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_bus_error <= w_bus_error_d;
      if (w_latch) begin
        r_req_addr  <= mem_addr;
        r_req_wen   <= mem_wen;
        r_req_wdata <= mem_wdata;
        r_req_size  <= data_size;
      end
      // Read-before-write: a write access returns the old word.
      if (w_access) r_rdata <= w_in_range ? r_mem[w_req_idx] : '0;
    end
  end

  // Array contents survive reset; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_lanes[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  assign mem_rdata  = r_rdata;
  assign resp_valid = (r_state == StResp);
  assign bus_error  = r_bus_error;
  assign mem_stall  = ((r_state == StIdle) && mem_en && !w_post) || (r_state == StBusy);

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Self-checking bench for dmem_sram_responder: transaction-level model plus directed vectors.
// Honours DMEM_POSTED_WRITE_EN when compiled with it.
module tb_dmem_sram_responder;

  localparam int AW = 12;
  localparam int WC = 2;
`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en, mem_stall, resp_valid, bus_error;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  data_size;
  logic        z_en, z_stall, z_resp, z_err;
  logic [31:0] z_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_sram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .data_size(data_size), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .resp_valid(resp_valid), .bus_error(bus_error)
  );

  dmem_sram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_en(z_en), .mem_wen(4'b0000), .mem_addr(32'h0000_0040),
    .mem_wdata(32'h0), .data_size(3'd2), .mem_rdata(z_rdata),
    .mem_stall(z_stall), .resp_valid(z_resp), .bus_error(z_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mmem  [int];
  bit          known [int];
  int          acc    = -1;
  int          err_at = -1;
  bit          live   = 1'b0;
  logic [3:0]  a_wen;
  logic [31:0] a_addr, a_wdata, a_rdata, hold;
  bit          a_err, a_known, hold_known;
  bit          pw_v = 1'b0;
  int          pw_idx;
  logic [3:0]  pw_wen;
  logic [31:0] pw_data;

  function automatic bit oor(input logic [31:0] a);
    return a[31:AW+2] != '0;
  endfunction

  task automatic put(input int ix, input logic [3:0] wen, input logic [31:0] d);
    logic [31:0] w;
    w = mmem.exists(ix) ? mmem[ix] : 32'h0;
    for (int i = 0; i < 4; i++) if (wen[i]) w[8*i +: 8] = d[8*i +: 8];
    known[ix] = (known.exists(ix) && known[ix]) || (wen == 4'b1111);
    mmem[ix]  = w;
  endtask

  always @(negedge clk) begin
    bit es, er, ee;
    int ix;
    if (!rst) begin
      acc = -1; err_at = -1; pw_v = 1'b0; hold = '0; hold_known = 1'b1; live = 1'b1;
    end else if (live) begin
      es = 1'b0; er = 1'b0; ee = 1'b0;
      if (pw_v) begin
        put(pw_idx, pw_wen, pw_data);
        pw_v = 1'b0;
      end
      if (acc >= 0 && cyc > acc + WC + 2) acc = -1;
      if (acc >= 0) begin
        es = (cyc <= acc + WC + 1);
        if (cyc == acc + WC + 1) begin
          if (oor(a_addr)) begin
            a_rdata = '0; a_known = 1'b1; a_err = 1'b1;
          end else begin
            ix      = int'(a_addr[AW+1:2]);
            a_known = known.exists(ix) && known[ix];
            a_rdata = mmem.exists(ix) ? mmem[ix] : 32'h0;
            a_err   = 1'b0;
            put(ix, a_wen, a_wdata);
          end
        end
        if (cyc == acc + WC + 2) begin
          er = 1'b1; ee = a_err; hold = a_rdata; hold_known = a_known;
        end
      end else if (mem_en) begin
        if (POSTED && mem_wen != 4'b0000) begin
          if (oor(mem_addr)) err_at = cyc + 1;
          else begin
            pw_v = 1'b1; pw_idx = int'(mem_addr[AW+1:2]); pw_wen = mem_wen; pw_data = mem_wdata;
          end
        end else begin
          acc = cyc; es = 1'b1; a_wen = mem_wen; a_addr = mem_addr; a_wdata = mem_wdata;
        end
      end
      if (cyc == err_at) ee = 1'b1;
      chk("mem_stall", 32'(mem_stall), 32'(es));
      chk("resp_valid", 32'(resp_valid), 32'(er));
      chk("bus_error", 32'(bus_error), 32'(ee));
      if (hold_known) chk("mem_rdata", mem_rdata, hold);
    end
  end

  // ---------------- W=0 response monitor ----------------
  bit z_mon = 1'b0;
  int z_resps[$];
  always @(negedge clk) begin
    if (z_mon && z_resp) begin
      z_resps.push_back(cyc);
      chk("z_stall_in_resp", 32'(z_stall), 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int lat, output logic err);
    int t0;
    mem_en = 1'b1; mem_wen = wen; mem_addr = a; mem_wdata = d;
    t0 = cyc; lat = -1; rd = '0; err = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd = mem_rdata; err = bus_error; lat = cyc - t0;
        break;
      end
    end
    tick;
    mem_en = 1'b0; mem_wen = '0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL req_timeout: no resp_valid for addr %h within 40 cycles", a);
    end
  endtask

  task automatic wr(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int          l;
    logic        e;
    if (POSTED) begin
      mem_en = 1'b1; mem_wen = wen; mem_addr = a; mem_wdata = d;
      @(negedge clk);
      chk("post_stall", 32'(mem_stall), 32'd0);
      tick;
      mem_en = 1'b0; mem_wen = '0;
    end else begin
      req(wen, a, d, r, l, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        er;
    int          t0;
    mem_en = 1'b0; mem_wen = '0; mem_addr = '0; mem_wdata = '0; data_size = 3'd2; z_en = 1'b0;
    rst = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    chk("reset_stall", 32'(mem_stall), 32'd0);
    chk("reset_resp", 32'(resp_valid), 32'd0);
    chk("reset_err", 32'(bus_error), 32'd0);
    chk("reset_rdata", mem_rdata, 32'd0);
    tick;
    rst = 1'b1;
    tick;

    // Full-handshake word write and read back.
    req(4'b1111, 32'h10, 32'hDEAD_BEEF, rd, lat, er);
    chk("wr_latency", 32'(lat), 32'd4);
    req(4'b0000, 32'h10, 32'h0, rd, lat, er);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_word", rd, 32'hDEAD_BEEF);

    // Byte-lane merge; the write returns the old word.
    req(4'b0100, 32'h10, 32'h5555_5555, rd, lat, er);
    chk("merge_old_word", rd, 32'hDEAD_BEEF);
    req(4'b0000, 32'h13, 32'h0, rd, lat, er);
    chk("rd_merge", rd, 32'hDE55_BEEF);

    // Out-of-range write must not alias onto word 0.
    wr(4'b1111, 32'h0, 32'h0BAD_F00D);
    if (POSTED) begin
      mem_en = 1'b1; mem_wen = 4'b1111; mem_addr = 32'h4000; mem_wdata = 32'hFFFF_FFFF;
      tick;
      mem_en = 1'b0; mem_wen = '0;
      @(negedge clk);
      chk("oor_post_err", 32'(bus_error), 32'd1);
      tick;
    end else begin
      req(4'b1111, 32'h4000, 32'hFFFF_FFFF, rd, lat, er);
      chk("oor_err", 32'(er), 32'd1);
      chk("oor_rdata", rd, 32'd0);
    end
    req(4'b0000, 32'h0, 32'h0, rd, lat, er);
    chk("oor_word0_kept", rd, 32'h0BAD_F00D);
    chk("oor_read_err", 32'(er), 32'd0);

    // Consecutive writes, then read immediately after.
    wr(4'b1111, 32'h20, 32'h1111_1111);
    wr(4'b1111, 32'h24, 32'h2222_2222);
    req(4'b0000, 32'h24, 32'h0, rd, lat, er);
    chk("rd_0x24", rd, 32'h2222_2222);
    req(4'b0000, 32'h20, 32'h0, rd, lat, er);
    chk("rd_0x20", rd, 32'h1111_1111);

    // Reset in the cycle after a write is accepted loses that write.
    wr(4'b1111, 32'h28, 32'hAAAA_0000);
    tick;
    mem_en = 1'b1; mem_wen = 4'b1111; mem_addr = 32'h28; mem_wdata = 32'h1234_5678;
    tick;
    mem_en = 1'b0; mem_wen = '0; rst = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    req(4'b0000, 32'h28, 32'h0, rd, lat, er);
    chk("abort_keeps_old", rd, 32'hAAAA_0000);

    // WAIT_CYCLES=0: request held high, re-presented as soon as stall falls.
    tick;
    z_en = 1'b1; t0 = cyc; z_mon = 1'b1;
    repeat (9) tick;
    z_en = 1'b0;
    repeat (6) tick;
    z_mon = 1'b0;
    chk("z_resp_count", 32'(z_resps.size()), 32'd3);
    for (int k = 0; k < 3 && k < z_resps.size(); k++) begin
      chk("z_resp_cycle", 32'(z_resps[k] - t0), 32'(2 + 3 * k));
    end

    repeat (2) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
